// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO input arbiter.
// The lock state type is only used when FIFO_ARB_LOCK_EN is defined.
package fifo_arb_pkg;

    // Largest requester count the arbiter is sized for.
    localparam int MAX_REQ = 16;

    // Burst-lock state: IDLE arbitrates every beat, LOCKED pins the grant to one owner.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of idx among n requesters, wrapping to 0.
    function automatic int next_ptr(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotate-priority encoder: scans eligible requests starting
// at ptr and wrapping to ptr-1, returning the first hit as one-hot and index.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [TAG_WIDTH-1:0] ptr,
    input  logic [NUM_REQ-1:0]   mask,
    output logic [NUM_REQ-1:0]   grant,
    output logic [TAG_WIDTH-1:0] grant_idx,
    output logic                 any
);

    logic [NUM_REQ-1:0] elig;

    assign elig = req & mask;

    // First eligible requester at or after ptr, in circular order.
    always_comb begin : p_search
        int                   pos;
        logic [TAG_WIDTH-1:0] pos_w;
        pos       = 0;
        pos_w     = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_w = TAG_WIDTH'(pos);
            if (!any && elig[pos_w]) begin
                any          = 1'b1;
                grant[pos_w] = 1'b1;
                grant_idx    = pos_w;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO input port among NUM_REQ valid/ready
// producers through a single registered output stage tagged with the winner.
// Optional burst lock (req_last port plus IDLE/LOCKED FSM) is compiled in
// when FIFO_ARB_LOCK_EN is defined; the default build arbitrates every beat.
module fifo_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int TAG_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    import fifo_arb_pkg::*;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("fifo_rr_arbiter: NUM_REQ must be in 2..%0d", MAX_REQ);
    end

    logic                  load;
    logic                  xfer;
    logic                  any;
    logic                  ptr_adv;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    elig_mask;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] req_arr [NUM_REQ];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
    logic [TAG_WIDTH-1:0]  ptr_q,       ptr_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // The stage can take a new beat when it is empty or being drained this cycle.
    assign load      = !out_valid_q || out_ready;
    assign xfer      = load && any && !rst;
    assign req_ready = (load && !rst) ? grant : '0;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .mask      (elig_mask),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

`ifdef FIFO_ARB_LOCK_EN
    arb_state_e           state_q, state_d;
    logic [TAG_WIDTH-1:0] lock_idx_q, lock_idx_d;

    // Lock state and owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A non-final beat opens a burst; the owner's final beat closes it.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer && !req_last[grant_idx]) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = grant_idx;
                end
            end
            ARB_LOCKED: begin
                if (xfer && req_last[grant_idx]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // While locked only the owner is eligible, even if it is momentarily idle.
    always_comb begin
        elig_mask = '1;
        if (state_q == ARB_LOCKED) begin
            elig_mask            = '0;
            elig_mask[lock_idx_q] = 1'b1;
        end
    end

    // Pointer holds during a burst and steps past the owner on its last beat;
    // in LOCKED any transfer comes from the owner, so grant_idx is lock_idx.
    assign ptr_adv = xfer && ((state_q == ARB_IDLE) || req_last[grant_idx]);
`else
    assign elig_mask = '1;
    assign ptr_adv   = xfer;
`endif

    // Pointer moves past the winner of every counted transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_adv) begin
            ptr_d = TAG_WIDTH'(next_ptr(int'(grant_idx), NUM_REQ));
        end
    end

    // Output stage: refill on load, otherwise hold the pending beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = req_arr[grant_idx];
                out_tag_d  = grant_idx;
            end
        end
    end

    // Output and pointer registers; reset drops any registered beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter (NUM_REQ=4, DATA_WIDTH=32).
// Burst-lock sequences are included when FIFO_ARB_LOCK_EN is defined.
module tb_fifo_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
`ifdef FIFO_ARB_LOCK_EN
    logic [3:0]   req_last;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_tag;

    int checks = 0;
    int errors = 0;

    logic [33:0] sb [$];

    fifo_rr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
`ifdef FIFO_ARB_LOCK_EN
        .req_last  (req_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] s);
        return {s ^ 32'h3030_0003, s ^ 32'h2020_0002, s ^ 32'h1010_0001, s};
    endfunction

    // Drive one cycle of requests, check the grant and queue the beat it produces.
    task automatic step(input logic [3:0] v, input logic [127:0] d,
                        input logic [3:0] exp_rdy, input string name);
        req_valid = v;
        req_data  = d;
        #1;
        chk(name, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) sb.push_back({2'(i), d[i*32 +: 32]});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got tag %0d data %h want none", out_tag, out_data);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                chk("beat_tag", 32'(out_tag), 32'(e[33:32]));
                chk("beat_data", out_data, e[31:0]);
            end
        end
    end

    initial begin
        logic [127:0] hold_d;
        logic [31:0]  hold_exp;

        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = mk(32'h1234_0000);
        out_ready = 1'b1;
`ifdef FIFO_ARB_LOCK_EN
        req_last  = 4'hF;
`endif

        // Reset held with every requester asking.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_valid", 32'(out_valid), 32'h0);
        end
        req_valid = 4'h0;
        rst       = 1'b0;
        #1;
        chk("post_rst_tag", 32'(out_tag), 32'h0);
        chk("post_rst_data", out_data, 32'h0);
        @(posedge clk);
        #1;

        // Single request from 2; beat appears the next cycle, ptr becomes 3.
        step(4'b0100, {32'h0, 32'h0000_CAFE, 64'h0}, 4'b0100, "single_rdy");
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_tag", 32'(out_tag), 32'h2);
        chk("single_data", out_data, 32'h0000_CAFE);

        // ptr=3 with 0 and 1 asking: wraps to 0, then 1.
        step(4'b0011, mk(32'h5000_0000), 4'b0001, "wrap_0");
        step(4'b0011, mk(32'h5000_0001), 4'b0010, "wrap_1");
        // ptr=2: only 3 asking, which returns ptr to 0.
        step(4'b1000, mk(32'h6000_0000), 4'b1000, "to_ptr0");

        // Full rotation, one beat per cycle: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            step(4'hF, mk(32'h7000_0000 + 32'(k)), 4'(1 << (k % 4)), "rot_rdy");
        end

        // Backpressure: beat from 3 must hold while inputs keep changing.
        hold_d    = mk(32'h7000_0007);
        hold_exp  = hold_d[127:96];
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'hF;
            req_data  = mk(32'h9999_0000 + 32'(k));
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_tag", 32'(out_tag), 32'h3);
            chk("bp_data", out_data, hold_exp);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        step(4'hF, mk(32'h8000_0000), 4'b0001, "bp_release");
        step(4'h0, mk(32'h8000_0001), 4'b0000, "idle_rdy");
        chk("idle_valid", 32'(out_valid), 32'h0);

        // Reset while a beat sits in the output stage.
        req_valid = 4'b0010;
        req_data  = mk(32'hA000_0000);
        @(posedge clk);
        #1;
        chk("mid_loaded", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'h0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_after_valid", 32'(out_valid), 32'h0);
        // ptr is back to 0, so 1 wins over 2.
        step(4'b0110, mk(32'hB000_0000), 4'b0010, "ptr_reset");

`ifdef FIFO_ARB_LOCK_EN
        // ptr=2: single-beat burst from 0 leaves ptr at 1.
        step(4'b0001, mk(32'hC000_0000), 4'b0001, "lock_pre");
        req_last = 4'b0000;
        step(4'b0111, mk(32'hC000_0001), 4'b0010, "lock_b1");
        step(4'b0101, mk(32'hC000_0002), 4'b0000, "lock_gap");
        step(4'b0111, mk(32'hC000_0003), 4'b0010, "lock_b2");
        req_last = 4'b0010;
        step(4'b0111, mk(32'hC000_0004), 4'b0010, "lock_b3");
        req_last = 4'hF;
        step(4'b0111, mk(32'hC000_0005), 4'b0100, "lock_after2");
        step(4'b0111, mk(32'hC000_0006), 4'b0001, "lock_after0");
`endif

        // Drain and confirm every expected beat was seen.
        step(4'h0, 128'h0, 4'b0000, "drain_rdy");
        @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
